// File: rtl/nibble_serial_adder.sv
// Computes a W-bit add/subtract by driving one external 4-bit adder stage, one nibble per clock.
// Latency: done pulses in the cycle after the NIBBLES-th RUN edge; a start seen while busy is dropped, not queued.
module nibble_serial_adder #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
    input  logic         sub,
    output logic [3:0]   add_A,
    output logic [3:0]   add_B,
    output logic         add_Cin,
    input  logic [3:0]   add_Sum,
    input  logic         add_Cout,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         overflow,
    output logic         busy,
    output logic         done
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_result;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic          r_cout;
    logic          r_ovf;
    logic          r_done;
    logic          r_busy;

    logic          w_run;
    logic [W-1:0]  w_a_shift;
    logic [W-1:0]  w_b_shift;

    // Adder operands come only from registers, so there is no input-to-output path.
    assign w_run     = (r_state == S_RUN);
    assign w_a_shift = r_a >> {r_idx, 2'b00};
    assign w_b_shift = r_b >> {r_idx, 2'b00};
    assign add_A     = w_run ? w_a_shift[3:0] : 4'h0;
    assign add_B     = w_run ? w_b_shift[3:0] : 4'h0;
    assign add_Cin   = w_run ? r_carry : 1'b0;

    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;
    assign busy     = r_busy;
    assign done     = r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= op_a;
                        r_b      <= sub ? ~op_b : op_b;
                        r_carry  <= sub ? 1'b1 : cin;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (r_idx == IW'(n)) begin
                            r_result[4*n +: 4] <= add_Sum;
                        end
                    end
                    r_carry <= add_Cout;
                    if (r_idx == LAST_IDX) begin
                        // Sign overflow: like-signed operands producing a differently-signed top nibble.
                        r_cout  <= add_Cout;
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) && (add_Sum[3] != r_a[W-1]);
                        r_done  <= 1'b1;
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: a behavioural 4-bit adder slice is attached, and each accepted start
// queues its expected result, which a separate monitor checks whenever done is seen.
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;
    localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (W - 1));

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic [3:0]   add_A, add_B, add_Sum;
    logic         add_Cin, add_Cout;
    logic [W-1:0] result;
    logic         cout, overflow, busy, done;
    logic [4:0]   w_sum5;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   dones = 0;
    int   exp_dones = 0;
    exp_t q[$];
    exp_t last_exp;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .cin(cin), .sub(sub), .add_A(add_A), .add_B(add_B), .add_Cin(add_Cin),
        .add_Sum(add_Sum), .add_Cout(add_Cout), .result(result), .cout(cout),
        .overflow(overflow), .busy(busy), .done(done)
    );

    assign w_sum5   = {1'b0, add_A} + {1'b0, add_B} + {4'b0, add_Cin};
    assign add_Sum  = w_sum5[3:0];
    assign add_Cout = w_sum5[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        exp_t   e;
        longint ua, ub, sa, sb, r, ss;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            r      = ua - ub;
            e.cout = (ua >= ub);
            ss     = sa - sb;
        end else begin
            r      = ua + ub + longint'(c);
            e.cout = (r >= (longint'(1) << W));
            ss     = sa + sb + longint'(c);
        end
        e.res = r[W-1:0];
        e.ovf = (ss > MAXS) || (ss < MINS);
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation, including its timing.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            dones++;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done result=%h (t=%0t)", result, $time);
            end else begin
                e = q.pop_front();
                chk("result", result, e.res);
                chk("cout", cout, e.cout);
                chk("overflow", overflow, e.ovf);
                chk("done_latency", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL wait_idle_timeout busy=%b required=0", busy);
        end
    endtask

    // Returns #1 after the accept edge with start already dropped and operands scrambled.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        exp_t e;
        wait_idle();
        op_a  = a;
        op_b  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        e     = model(a, b, c, s);
        e.cyc = cyc + N;
        q.push_back(e);
        exp_dones++;
        last_exp = e;
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'($urandom);
        sub   = 1'($urandom);
    endtask

    initial begin
        logic [3:0] seq [4];
        exp_t       prev;
        exp_t       e;
        int         c0;
        int         n;
        seq[0] = 4'h4; seq[1] = 4'h3; seq[2] = 4'h2; seq[3] = 4'h1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addA", add_A, 0);
        rst_n = 1'b1;

        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("add_A_seq", add_A, seq[k]);
            @(posedge clk);
            #1;
        end
        chk("add_A_done", add_A, 0);
        chk("add_Cin_done", add_Cin, 0);

        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        prev = last_exp;
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        chk("result_clear_on_accept", result, 0);
        chk("cout_hold_on_accept", cout, prev.cout);
        issue(16'h0005, 16'h0007, 1'b0, 1'b1);
        issue(16'h0000, 16'h0000, 1'b1, 1'b0);
        wait_idle();
        repeat (5) @(negedge clk);
        chk("result_hold_idle", result, last_exp.res);

        // A second start during RUN must be dropped.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        op_a  = 16'hAAAA;
        op_b  = 16'h5555;
        @(negedge clk);
        start = 1'b0;

        // start held high: accepts land every N+2 cycles.
        wait_idle();
        op_a  = 16'h8000;
        op_b  = 16'h0001;
        sub   = 1'b1;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            e     = model(16'h8000, 16'h0001, 1'b0, 1'b1);
            e.cyc = c0 + N + (N + 2) * k;
            q.push_back(e);
            exp_dones++;
        end
        repeat (3 * (N + 2)) @(posedge clk);
        #1;
        start = 1'b0;

        // Reset while RUN is at idx 2: everything clears and no done follows.
        wait_idle();
        op_a  = 16'h1234;
        op_b  = 16'h1111;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_result", result, 0);
        chk("abort_cout", cout, 0);
        chk("abort_ovf", overflow, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_addA", add_A, 0);
        chk("abort_addB", add_B, 0);
        chk("abort_addCin", add_Cin, 0);
        repeat (8) @(negedge clk);
        issue(16'h0001, 16'h0001, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end

        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("done_count", dones, exp_dones);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
